event_byte_serializer: RTL and testbench

//  Downstream of the LOST event-capture stage: accepts 64-bit event records (timestamp+pin state)
//  via valid/ready, buffers up to 2 records, streams each out LSB byte first over a byte-wide

---
 rtl/event_byte_serializer_pkg.sv | 22 ++
 rtl/event_byte_serializer_if.sv | 30 +++
 rtl/event_byte_serializer_word_fifo2.sv | 45 ++++
 rtl/event_byte_serializer.sv | 116 +++++++++++
 tb/tb_event_byte_serializer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/event_byte_serializer_pkg.sv
// Shared types for the event byte serializer slice.
// Optional marker byte is enabled by defining SER_SYNC_MARKER_EN.
package lost_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    SEND
  } ser_state_t;

  localparam int BYTES_PER_WORD = 8;
  localparam int SEL_W = 3;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] word_byte(
    input logic [63:0] w,
    input logic [SEL_W-1:0] k
  );
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/event_byte_serializer_if.sv
// Record-in / byte-out handshake bundle for the serializer.
// slave is the serializer side, master the producer/sink side.
interface event_byte_serializer_if;

  logic [63:0] in_word;
  logic in_valid;
  logic in_ready;
  logic [7:0] out_byte;
  logic out_valid;
  logic out_ready;

  modport slave (
    input  in_word,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_byte,
    output out_valid
  );

  modport master (
    output in_word,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_byte,
    input  out_valid
  );

endinterface

// File: rtl/event_byte_serializer_word_fifo2.sv
// Two-entry 64-bit record FIFO with synchronous flush.
// Caller must not push when full nor pop when empty.
module word_fifo2 (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic [63:0] din,
  input  logic pop,
  output logic [63:0] dout,
  output logic full,
  output logic empty
);

  logic [63:0] mem [2];
  logic wp;
  logic rp;
  logic [1:0] cnt;

  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/event_byte_serializer.sv
// Buffers 64-bit event records and streams them LSB byte first.
// Define SER_SYNC_MARKER_EN to prefix each record with SYNC_BYTE.
module event_byte_serializer
  import lost_ser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  event_byte_serializer_if.slave bus,
  output logic [SEL_W-1:0] byte_sel,
  output logic busy,
  output logic [CNT_W-1:0] word_count
);

`ifdef SER_SYNC_MARKER_EN
  localparam bit MARK = 1'b1;
  localparam ser_state_t FIRST = SYNC;
`else
  localparam bit MARK = 1'b0;
  localparam ser_state_t FIRST = SEND;
`endif

  ser_state_t state;
  logic [63:0] cur_word;
  logic [63:0] head;
  logic [7:0] obyte;
  logic ovld;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic hs;
  logic last;

  assign bus.in_ready = !full && !flush;
  assign bus.out_byte = obyte;
  assign bus.out_valid = ovld;

  assign push = bus.in_valid && !full && !flush;
  assign hs = ovld && bus.out_ready;
  assign last = byte_sel == SEL_W'(BYTES_PER_WORD - 1);
  assign busy = (state != IDLE) || !empty;

  // Reload straight from the FIFO on the last byte so records run back to back.
  assign pop = !flush && !empty &&
               ((state == IDLE) ||
                (state == SEND && hs && last));

  word_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (bus.in_word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_word <= '0;
      obyte <= '0;
      ovld <= 1'b0;
      byte_sel <= '0;
      word_count <= '0;
    end else if (flush) begin
      state <= IDLE;
      ovld <= 1'b0;
      byte_sel <= '0;
    end else begin
      if (state == SEND && hs && last)
        word_count <= word_count + CNT_W'(1);
      if (pop) begin
        cur_word <= head;
        byte_sel <= '0;
        ovld <= 1'b1;
        state <= FIRST;
        obyte <= MARK ? SYNC_BYTE : head[7:0];
      end else begin
        unique case (state)
          IDLE: ;
`ifdef SER_SYNC_MARKER_EN
          SYNC: begin
            if (hs) begin
              state <= SEND;
              obyte <= cur_word[7:0];
            end
          end
`endif
          SEND: begin
            if (hs) begin
              if (last) begin
                state <= IDLE;
                ovld <= 1'b0;
              end else begin
                byte_sel <= byte_sel + SEL_W'(1);
                obyte <= word_byte(cur_word, byte_sel + SEL_W'(1));
              end
            end
          end
          default: begin
            state <= IDLE;
            ovld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_event_byte_serializer.sv
// Self-checking bench: byte-stream reference model plus directed corners.
// Expects the marker byte when SER_SYNC_MARKER_EN is defined.
module tb_event_byte_serializer;

  localparam int CW = 5;
`ifdef SER_SYNC_MARKER_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct {
    logic [63:0] w;
    logic [7:0] b0;
    logic [7:0] b7;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [2:0] byte_sel;
  logic busy;
  logic [CW-1:0] word_count;

  event_byte_serializer_if bus ();

  event_byte_serializer #(
    .SYNC_BYTE (8'hA5),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .byte_sel   (byte_sel),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int nfail = 0;

  logic [7:0] eb[$];
  logic [2:0] es[$];
  bit el[$];
  logic [7:0] got[$];
  logic [CW-1:0] ecnt = '0;
  bit pv = 0;
  logic [7:0] pb;
  logic [2:0] ps;
  bit last_acc = 0;
  bit last_inrdy = 1;
  bit last_ov = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    nfail++;
    if (nfail <= 40) $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic void model_push(input logic [63:0] w);
    if (NB == 9) begin
      eb.push_back(8'hA5);
      es.push_back(3'd0);
      el.push_back(1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      eb.push_back(w[8*k +: 8]);
      es.push_back(3'(k));
      el.push_back(k == 7);
    end
  endfunction

  function automatic void model_clear();
    eb.delete();
    es.delete();
    el.delete();
    pv = 0;
  endfunction

  // One clock: sample mid-low-phase, update model, advance to next negedge.
  task automatic cyc();
    #1;
    chk("word_count", word_count, ecnt);
    last_inrdy = bus.in_ready;
    last_ov = bus.out_valid;
    last_acc = 0;
    if (flush) begin
      chk("in_ready_flush", bus.in_ready, 0);
      model_clear();
    end else begin
      if (pv) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_byte", bus.out_byte, pb);
        chk("stall_sel", byte_sel, ps);
      end
      if (bus.in_valid && bus.in_ready) begin
        last_acc = 1;
        model_push(bus.in_word);
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_byte);
        if (eb.size() == 0) bad("unexpected_byte");
        else begin
          chk("out_byte", bus.out_byte, eb.pop_front());
          chk("byte_sel", byte_sel, es.pop_front());
          if (el.pop_front()) ecnt++;
        end
      end
      pv = bus.out_valid && !bus.out_ready;
      pb = bus.out_byte;
      ps = byte_sel;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    bus.out_ready = 1;
    while ((eb.size() != 0 || busy) && n < maxc) begin
      cyc();
      n++;
    end
    if (n >= maxc) bad("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    logic [63:0] w3[3];
    int idx;
    int run;
    int maxrun;
    bit saw_nr;
    logic [CW-1:0] base;
    int n;

    tbl[0] = '{64'h0807060504030201, 8'h01, 8'h08};
    tbl[1] = '{64'h1122334455667788, 8'h88, 8'h11};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF};
    tbl[3] = '{64'h00000000000000A5, 8'hA5, 8'h00};
    tbl[4] = '{64'h8000000000000001, 8'h01, 8'h80};

    bus.in_word = '0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_byte", bus.out_byte, 0);
    chk("rst_byte_sel", byte_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", word_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Single record and first-byte latency.
    bus.in_word = 64'h0807060504030201;
    bus.in_valid = 1;
    bus.out_ready = 1;
    cyc();
    bus.in_valid = 0;
    #1;
    chk("lat_n_valid", bus.out_valid, 0);
    chk("lat_n_busy", busy, 1);
    cyc();
    #1;
    chk("lat_n1_valid", bus.out_valid, 1);
`ifdef SER_SYNC_MARKER_EN
    chk("lat_n1_byte", bus.out_byte, 8'hA5);
`else
    chk("lat_n1_byte", bus.out_byte, 8'h01);
`endif
    chk("lat_n1_sel", byte_sel, 0);
    drain(40);
    chk("single_count", word_count, 1);

    // Table of isolated records.
    for (int i = 0; i < 5; i++) begin
      got.delete();
      bus.in_word = tbl[i].w;
      bus.in_valid = 1;
      cyc();
      bus.in_valid = 0;
      drain(40);
      chk("tbl_len", got.size(), NB);
      chk("tbl_b0", got[NB-8], tbl[i].b0);
      chk("tbl_b7", got[NB-1], tbl[i].b7);
`ifdef SER_SYNC_MARKER_EN
      chk("tbl_sync", got[0], 8'hA5);
`endif
    end

    // Three records back to back: no bubbles, FIFO fills.
    w3[0] = 64'hA1A2A3A4A5A6A7A8;
    w3[1] = 64'h0123456789ABCDEF;
    w3[2] = 64'hDEADBEEFCAFEF00D;
    base = ecnt;
    idx = 0;
    run = 0;
    maxrun = 0;
    saw_nr = 0;
    bus.out_ready = 1;
    for (int c = 0; c < 50; c++) begin
      bus.in_valid = idx < 3;
      bus.in_word = w3[idx < 3 ? idx : 0];
      cyc();
      if (last_acc) idx++;
      if (!last_inrdy) saw_nr = 1;
      run = last_ov ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    bus.in_valid = 0;
    drain(40);
    chk("b2b_accepted", idx, 3);
    chk("b2b_run", maxrun, 3 * NB);
    chk("b2b_in_ready_low", saw_nr, 1);
    chk("b2b_count", word_count, base + CW'(3));

    // Random traffic with sink stalls.
    bus.in_valid = 0;
    last_acc = 0;
    for (int c = 0; c < 900; c++) begin
      bus.out_ready = ($urandom % 3) != 0;
      if (!(bus.in_valid && !last_acc)) begin
        bus.in_valid = ($urandom % 2) == 0;
        bus.in_word = {$urandom, $urandom};
      end
      cyc();
    end
    bus.in_valid = 0;
    drain(200);
    chk("rand_drained", eb.size(), 0);

    // Flush mid-record with one record queued.
    bus.out_ready = 1;
    idx = 0;
    for (int c = 0; c < 6 && idx < 2; c++) begin
      bus.in_valid = 1;
      bus.in_word = {$urandom, $urandom};
      cyc();
      if (last_acc) idx++;
    end
    bus.in_valid = 0;
    n = 0;
    #1;
    while (!(bus.out_valid && byte_sel == 3'd4 && eb.size() > 0) && n < 40) begin
      cyc();
      #1;
      n++;
    end
    if (n >= 40) bad("flush_wait_timeout");
    base = ecnt;
    flush = 1;
    bus.in_valid = 1;
    bus.in_word = 64'h5555AAAA5555AAAA;
    cyc();
    flush = 0;
    bus.in_valid = 0;
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_sel", byte_sel, 0);
    chk("flush_count", word_count, base);
    repeat (15) cyc();

    // Asynchronous reset in the middle of a record.
    bus.in_word = 64'h1357924680ACEBDF;
    bus.in_valid = 1;
    cyc();
    bus.in_valid = 0;
    n = 0;
    #1;
    while (!(bus.out_valid && byte_sel == 3'd3) && n < 40) begin
      cyc();
      #1;
      n++;
    end
    if (n >= 40) bad("reset_wait_timeout");
    #1;
    rst_n = 0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_byte", bus.out_byte, 0);
    chk("arst_sel", byte_sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", word_count, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    model_clear();
    ecnt = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (15) cyc();
    bus.in_word = 64'h1122334455667788;
    bus.in_valid = 1;
    cyc();
    bus.in_valid = 0;
    drain(40);
    chk("post_rst_count", word_count, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
